mvu_dload: RTL and testbench

MVU_DLOAD -- requirements
Module: mvu_dload

---
 rtl/mvu_pkg.sv | 14 +
 rtl/mvu_dload.sv | 134 +++++++++++++
 tb/tb_mvu_dload.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mvu_pkg.sv
// Shared MVU definitions: data-bank/length widths and the data-load FSM state type.
package mvu_pkg;

  localparam int BDBANKA = 15;
  localparam int BLENGTH = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } dload_state_e;

endpackage

// File: rtl/mvu_dload.sv
// Stream-to-data-bank loader: accepts a burst of stream words and writes them
// to the MVU data bank at base + k*stride through a single-register output stage.
module mvu_dload #(
  parameter int N       = 64,
  parameter int BDBANKA = mvu_pkg::BDBANKA,
  parameter int BLENGTH = mvu_pkg::BLENGTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_start,
  input  logic [BDBANKA-1:0] cfg_baseaddr,
  input  logic [BDBANKA-1:0] cfg_stride,
  input  logic [BLENGTH-1:0] cfg_length,
  input  logic               cfg_abort,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [N-1:0]       s_data,
  output logic               wrc_en,
  input  logic               wrc_grnt,
  output logic [BDBANKA-1:0] wrc_addr,
  output logic [N-1:0]       wrc_word,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [BLENGTH-1:0] wcount
);
  import mvu_pkg::*;

  dload_state_e       state_q;
  logic [BDBANKA-1:0] stride_q;
  logic [BDBANKA-1:0] next_addr_q;
  logic [BDBANKA-1:0] wrc_addr_q;
  logic [N-1:0]       wrc_word_q;
  logic [BLENGTH-1:0] len_q;
  logic [BLENGTH-1:0] acc_q;
  logic [BLENGTH-1:0] wcount_q;
  logic               wrc_en_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  logic accept;
  logic granted;
  logic last_beat;
  logic aborting;

  // The output register may take a new beat whenever it is empty or draining this cycle.
  assign s_ready   = (state_q == RUN) && (!wrc_en_q || wrc_grnt);
  assign accept    = s_valid && s_ready;
  assign granted   = wrc_en_q && wrc_grnt;
  assign last_beat = accept && (acc_q == len_q - BLENGTH'(1));
  assign aborting  = cfg_abort && ((state_q == RUN) || (state_q == DRAIN));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      stride_q    <= '0;
      next_addr_q <= '0;
      wrc_addr_q  <= '0;
      wrc_word_q  <= '0;
      len_q       <= '0;
      acc_q       <= '0;
      wcount_q    <= '0;
      wrc_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= (cfg_start && (state_q != IDLE));

      if (granted && (wcount_q != '1)) wcount_q <= wcount_q + BLENGTH'(1);

      // Address accumulates by stride per accepted beat; wrap-around is modular.
      if (accept) begin
        wrc_en_q    <= 1'b1;
        wrc_addr_q  <= next_addr_q;
        wrc_word_q  <= s_data;
        next_addr_q <= next_addr_q + stride_q;
        acc_q       <= acc_q + BLENGTH'(1);
      end else if (granted) begin
        wrc_en_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (cfg_start) begin
            stride_q    <= cfg_stride;
            len_q       <= cfg_length;
            next_addr_q <= cfg_baseaddr;
            acc_q       <= '0;
            wcount_q    <= '0;
            if (cfg_length != '0) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end else begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (last_beat) state_q <= DRAIN;
        end
        DRAIN: begin
          if (granted) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      // Abort overrides the normal flow; a grant in the same cycle still counted above.
      if (aborting) begin
        state_q  <= FIN;
        busy_q   <= 1'b0;
        done_q   <= 1'b1;
        wrc_en_q <= 1'b0;
      end
    end
  end

  assign wrc_en   = wrc_en_q;
  assign wrc_addr = wrc_addr_q;
  assign wrc_word = wrc_word_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign wcount   = wcount_q;

endmodule

// File: tb/tb_mvu_dload.sv
// Directed, table-driven bench for mvu_dload with hand-computed addresses and timing.
module tb_mvu_dload;
  localparam int N  = 64;
  localparam int BA = 15;
  localparam int BL = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_start;
  logic [BA-1:0] cfg_baseaddr;
  logic [BA-1:0] cfg_stride;
  logic [BL-1:0] cfg_length;
  logic          cfg_abort;
  logic          s_valid;
  logic          s_ready;
  logic [N-1:0]  s_data;
  logic          wrc_en;
  logic          wrc_grnt;
  logic [BA-1:0] wrc_addr;
  logic [N-1:0]  wrc_word;
  logic          busy;
  logic          done;
  logic          err;
  logic [BL-1:0] wcount;

  always #5 clk = ~clk;

  mvu_dload #(.N(N), .BDBANKA(BA), .BLENGTH(BL)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_baseaddr(cfg_baseaddr), .cfg_stride(cfg_stride),
    .cfg_length(cfg_length), .cfg_abort(cfg_abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .wrc_en(wrc_en), .wrc_grnt(wrc_grnt), .wrc_addr(wrc_addr), .wrc_word(wrc_word),
    .busy(busy), .done(done), .err(err), .wcount(wcount)
  );

  typedef struct {
    logic [BA-1:0]        base;
    logic [BA-1:0]        stride;
    logic [BL-1:0]        length;
    int                   stall_word;
    int                   stall_cycles;
    int                   restart_cyc;
    int                   abort_after;
    logic [3:0][BA-1:0]   exp_addr;
    int                   exp_wcount;
    int                   exp_done_cyc;
  } vec_t;

  vec_t vecs [7];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] data_for(input int v, input int k);
    return {32'hC0DE0000 + 32'(v), 32'(k)};
  endfunction

  task automatic set_vec(input int i, input logic [BA-1:0] base, input logic [BA-1:0] stride,
                         input logic [BL-1:0] len, input int sw, input int sc, input int rc,
                         input int ab, input logic [BA-1:0] a0, input logic [BA-1:0] a1,
                         input logic [BA-1:0] a2, input logic [BA-1:0] a3,
                         input int wc, input int dc);
    vecs[i].base = base;       vecs[i].stride = stride;     vecs[i].length = len;
    vecs[i].stall_word = sw;   vecs[i].stall_cycles = sc;
    vecs[i].restart_cyc = rc;  vecs[i].abort_after = ab;
    vecs[i].exp_addr[0] = a0;  vecs[i].exp_addr[1] = a1;
    vecs[i].exp_addr[2] = a2;  vecs[i].exp_addr[3] = a3;
    vecs[i].exp_wcount = wc;   vecs[i].exp_done_cyc = dc;
  endtask

  task automatic idle_inputs();
    cfg_start = 1'b0; cfg_abort = 1'b0; s_valid = 1'b0; wrc_grnt = 1'b0; s_data = '0;
  endtask

  // Runs one transfer; cycle 1 is the first cycle after the cfg_start edge.
  task automatic run_vec(input int v, input vec_t t);
    int wr_k;
    int acc_k;
    int stall_cnt;
    bit seen_done;
    bit stalling;
    wr_k = 0; acc_k = 0; stall_cnt = 0; seen_done = 1'b0;
    @(negedge clk);
    idle_inputs();
    cfg_start = 1'b1; cfg_baseaddr = t.base; cfg_stride = t.stride; cfg_length = t.length;
    for (int cyc = 1; cyc <= 200 && !seen_done; cyc++) begin
      @(negedge clk);
      cfg_start = (cyc == t.restart_cyc);
      if (cfg_start) begin
        cfg_baseaddr = 15'h0555; cfg_length = 15'd1;
      end
      if (cyc == 1 && t.length != 0) check($sformatf("v%0d busy_after_start", v), 64'(busy), 64'd1);
      if (t.restart_cyc > 0 && cyc == t.restart_cyc + 1)
        check($sformatf("v%0d err_pulse", v), 64'(err), 64'd1);
      if (done) begin
        seen_done = 1'b1;
        idle_inputs();
        check($sformatf("v%0d done_cycle", v), 64'(cyc), 64'(t.exp_done_cyc));
        check($sformatf("v%0d wcount", v), 64'(wcount), 64'(t.exp_wcount));
        check($sformatf("v%0d writes_seen", v), 64'(wr_k), 64'(t.exp_wcount));
        check($sformatf("v%0d busy_in_fin", v), 64'(busy), 64'd0);
        check($sformatf("v%0d wrc_en_in_fin", v), 64'(wrc_en), 64'd0);
        check($sformatf("v%0d err_in_fin", v), 64'(err), 64'd0);
        $display("v%0d: done at cycle %0d wcount=%0d", v, cyc, wcount);
      end else begin
        stalling = 1'b0;
        cfg_abort = (t.abort_after >= 0) && (wr_k == t.abort_after) && wrc_en;
        wrc_grnt = 1'b1;
        if (cfg_abort) begin
          wrc_grnt = 1'b0;
        end else if (wrc_en && wr_k == t.stall_word && stall_cnt < t.stall_cycles) begin
          wrc_grnt = 1'b0;
          stalling = 1'b1;
          stall_cnt++;
        end
        s_valid = 1'b1;
        s_data  = data_for(v, acc_k);
        #1;
        if (stalling) begin
          check($sformatf("v%0d stall_addr", v), 64'(wrc_addr), 64'(t.exp_addr[wr_k]));
          check($sformatf("v%0d stall_word", v), wrc_word, data_for(v, wr_k));
          check($sformatf("v%0d stall_ready", v), 64'(s_ready), 64'd0);
        end
        if (s_valid && s_ready) acc_k++;
        if (wrc_en && wrc_grnt) begin
          if (wr_k < 4) check($sformatf("v%0d addr%0d", v, wr_k), 64'(wrc_addr), 64'(t.exp_addr[wr_k]));
          check($sformatf("v%0d data%0d", v, wr_k), wrc_word, data_for(v, wr_k));
          $display("v%0d: cycle %0d write k=%0d addr=%04h", v, cyc, wr_k, wrc_addr);
          wr_k++;
        end
      end
    end
    if (!seen_done) check($sformatf("v%0d done_timeout", v), 64'd0, 64'd1);
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    //       idx base      stride   len  stallw stallc rst abort  a0       a1       a2       a3       wc dc
    set_vec(0, 15'h0010, 15'd1,    15'd4, -1, 0, 0, -1, 15'h0010, 15'h0011, 15'h0012, 15'h0013, 4, 6);
    set_vec(1, 15'h7FFE, 15'd3,    15'd3, -1, 0, 0, -1, 15'h7FFE, 15'h0001, 15'h0004, 15'h0000, 3, 5);
    set_vec(2, 15'h0100, 15'd2,    15'd4,  2, 5, 0, -1, 15'h0100, 15'h0102, 15'h0104, 15'h0106, 4, 11);
    set_vec(3, 15'h0200, 15'd1,    15'd0, -1, 0, 0, -1, 15'h0000, 15'h0000, 15'h0000, 15'h0000, 0, 1);
    set_vec(4, 15'h0000, 15'h4000, 15'd4, -1, 0, 0, -1, 15'h0000, 15'h4000, 15'h0000, 15'h4000, 4, 6);
    set_vec(5, 15'h0020, 15'd1,    15'd4, -1, 0, 2, -1, 15'h0020, 15'h0021, 15'h0022, 15'h0023, 4, 6);
    set_vec(6, 15'h0000, 15'd1,    15'd8, -1, 0, 0,  2, 15'h0000, 15'h0001, 15'h0002, 15'h0003, 2, 5);

    idle_inputs();
    cfg_baseaddr = '0; cfg_stride = '0; cfg_length = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset s_ready", 64'(s_ready), 64'd0);
    check("reset wrc_en", 64'(wrc_en), 64'd0);
    check("reset busy_done_err", {61'd0, busy, done, err}, 64'd0);
    check("reset wrc_addr", 64'(wrc_addr), 64'd0);
    check("reset wrc_word", wrc_word, 64'd0);
    check("reset wcount", 64'(wcount), 64'd0);
    $display("reset: outputs checked");
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a transfer: pending word discarded, no done.
    @(negedge clk);
    cfg_start = 1'b1; cfg_baseaddr = 15'h0300; cfg_stride = 15'd1; cfg_length = 15'd8;
    @(negedge clk);
    cfg_start = 1'b0; s_valid = 1'b1; wrc_grnt = 1'b1; s_data = 64'hDEAD;
    repeat (2) @(negedge clk);
    check("midrst pre wrc_en", 64'(wrc_en), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst wrc_en", 64'(wrc_en), 64'd0);
    check("midrst s_ready", 64'(s_ready), 64'd0);
    check("midrst busy_done_err", {61'd0, busy, done, err}, 64'd0);
    check("midrst addr_word_cnt", {15'(wrc_addr), 15'(wcount), 34'(wrc_word)}, 64'd0);
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst no_done", 64'(done), 64'd0);
    end
    $display("midrst: reset mid-transfer checked");
    run_vec(0, vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
